// File: rtl/fadd_pipe_if.sv
// Handshake bundle for the pipelined floating-point adder:
// operand side (in_*) and result side (out_*).
interface fadd_pipe_if #(
    parameter int unsigned N = 32
) ();
    logic         in_val;
    logic         in_rdy;
    logic         sub;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic         out_val;
    logic         out_rdy;
    logic [N-1:0] res;
    logic [2:0]   flags;

    modport master (
        output in_val, sub, op1, op2, out_rdy,
        input  in_rdy, out_val, res, flags
    );

    modport slave (
        input  in_val, sub, op1, op2, out_rdy,
        output in_rdy, out_val, res, flags
    );
endinterface

// File: rtl/fadd_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round)
// with round-to-nearest-even, flush-to-zero inputs and elastic handshake.
module fadd_pipe #(
    parameter int unsigned N = 32,
    parameter int unsigned E = 8
) (
    input  logic       clk,
    input  logic       rst,
    fadd_pipe_if.slave bus
);
    localparam int unsigned M  = N - E - 1;
    localparam int unsigned FW = M + 4;
    localparam int unsigned SW = M + 5;
    localparam int unsigned RW = M + 1;
    localparam int unsigned LW = $clog2(M + 5);
    localparam int unsigned XW = ((E > LW) ? E : LW) + 2;
    localparam logic [N-1:0]  QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [XW-1:0] EXP_OVF = XW'({E{1'b1}});

    // Stage occupancy and load enables; a stage loads when empty or draining.
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    assign ld3         = !v3 || bus.out_rdy;
    assign ld2         = !v2 || ld3;
    assign ld1         = !v1 || ld2;
    assign bus.in_rdy  = ld1;
    assign bus.out_val = v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= bus.in_val;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // S1: classify, order by magnitude, align the smaller operand
    logic          sgn1, sgn2, zero1, zero2, inf1, inf2, nan1, nan2, swap, sp_n;
    logic [E-1:0]  exp1, exp2, ea, eb, d;
    logic [M-1:0]  man1, man2, ma, mb;
    logic [M+2:0]  frac_b;
    logic [FW-1:0] a_al, b_al;
    logic [N-1:0]  sp_res_n;
    logic [2:0]    sp_flags_n;

    always_comb begin
        sgn1  = bus.op1[N-1];
        sgn2  = bus.op2[N-1] ^ bus.sub;
        exp1  = bus.op1[N-2:M];
        exp2  = bus.op2[N-2:M];
        man1  = bus.op1[M-1:0];
        man2  = bus.op2[M-1:0];
        zero1 = (exp1 == '0);
        zero2 = (exp2 == '0);
        inf1  = (exp1 == '1) && (man1 == '0);
        inf2  = (exp2 == '1) && (man2 == '0);
        nan1  = (exp1 == '1) && (man1 != '0);
        nan2  = (exp2 == '1) && (man2 != '0);
        swap  = (bus.op2[N-2:0] > bus.op1[N-2:0]);
        ea    = swap ? exp2 : exp1;
        eb    = swap ? exp1 : exp2;
        ma    = swap ? man2 : man1;
        mb    = swap ? man1 : man2;
        d     = ea - eb;
        frac_b = {1'b1, mb, 2'b00};
        a_al   = {1'b1, ma, 3'b000};
        if (32'(d) >= M + 3) begin
            b_al = {{(M+3){1'b0}}, 1'b1};
        end else begin
            b_al = {frac_b >> d, |(frac_b & ~({(M+3){1'b1}} << d))};
        end

        sp_n       = nan1 || nan2 || inf1 || inf2 || zero1 || zero2;
        sp_res_n   = '0;
        sp_flags_n = '0;
        if (nan1 || nan2 || (inf1 && inf2 && (sgn1 != sgn2))) begin
            sp_res_n   = QNAN;
            sp_flags_n = 3'b100;
        end else if (inf1) begin
            sp_res_n = {sgn1, bus.op1[N-2:0]};
        end else if (inf2) begin
            sp_res_n = {sgn2, bus.op2[N-2:0]};
        end else if (zero1 && zero2) begin
            // Opposite-sign zeros give +0; same-sign keep the sign.
            sp_res_n = {sgn1 & sgn2, {(N-1){1'b0}}};
        end else if (zero1) begin
            sp_res_n = {sgn2, bus.op2[N-2:0]};
        end else if (zero2) begin
            sp_res_n = bus.op1;
        end
    end

    logic          r1_sp, r1_sign, r1_sub;
    logic [N-1:0]  r1_sp_res;
    logic [2:0]    r1_sp_flags;
    logic [E-1:0]  r1_exp;
    logic [FW-1:0] r1_a, r1_b;

    always_ff @(posedge clk) begin
        if (ld1) begin
            r1_sp       <= sp_n;
            r1_sp_res   <= sp_res_n;
            r1_sp_flags <= sp_flags_n;
            r1_sign     <= swap ? sgn2 : sgn1;
            r1_sub      <= sgn1 ^ sgn2;
            r1_exp      <= ea;
            r1_a        <= a_al;
            r1_b        <= b_al;
        end
    end

    // S2: magnitude add or subtract; |A| >= |B| keeps the difference non-negative
    logic [SW-1:0] sum_n;

    assign sum_n = r1_sub ? ({1'b0, r1_a} - {1'b0, r1_b})
                          : ({1'b0, r1_a} + {1'b0, r1_b});

    logic          r2_sp, r2_sign;
    logic [N-1:0]  r2_sp_res;
    logic [2:0]    r2_sp_flags;
    logic [E-1:0]  r2_exp;
    logic [SW-1:0] r2_sum;

    always_ff @(posedge clk) begin
        if (ld2) begin
            r2_sp       <= r1_sp;
            r2_sp_res   <= r1_sp_res;
            r2_sp_flags <= r1_sp_flags;
            r2_sign     <= r1_sign;
            r2_exp      <= r1_exp;
            r2_sum      <= sum_n;
        end
    end

    // S3: normalise, round to nearest even, range check
    function automatic logic [LW-1:0] lzc(input logic [FW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (v[i]) n = LW'(int'(FW) - 1 - i);
        end
        return n;
    endfunction

    logic [LW-1:0] lz;
    logic [FW-1:0] norm;
    logic [XW-1:0] exp_n;
    logic [RW-1:0] rnd;
    logic          rnd_up, inexact;
    logic [N-1:0]  res_n;
    logic [2:0]    flags_n;

    always_comb begin
        lz    = '0;
        norm  = '0;
        exp_n = XW'(r2_exp);
        if (r2_sum[SW-1]) begin
            norm  = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
            exp_n = exp_n + XW'(1);
        end else begin
            lz    = lzc(r2_sum[FW-1:0]);
            norm  = r2_sum[FW-1:0] << lz;
            exp_n = exp_n - XW'(lz);
        end
        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        inexact = |norm[2:0];
        rnd     = {1'b0, norm[FW-2:3]} + RW'(rnd_up);
        if (rnd[RW-1]) exp_n = exp_n + XW'(1);

        res_n   = '0;
        flags_n = '0;
        if (r2_sp) begin
            res_n   = r2_sp_res;
            flags_n = r2_sp_flags;
        end else if (!norm[FW-1]) begin
            res_n   = '0;
        end else if ($signed(exp_n) >= $signed(EXP_OVF)) begin
            res_n   = {r2_sign, {E{1'b1}}, {M{1'b0}}};
            flags_n = 3'b011;
        end else if (exp_n[XW-1] || (exp_n == '0)) begin
            res_n   = {r2_sign, {(N-1){1'b0}}};
            flags_n = 3'b001;
        end else begin
            res_n   = {r2_sign, exp_n[E-1:0], rnd[M-1:0]};
            flags_n = {2'b00, inexact};
        end
    end

    logic [N-1:0] res_q;
    logic [2:0]   flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (ld3 && v2) begin
            res_q   <= res_n;
            flags_q <= flags_n;
        end
    end

    assign bus.res   = res_q;
    assign bus.flags = flags_q;
endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. Width and exponent size are configurable. It adds round-to-nearest-even (RNE), handling of special values (zero, infinity, NaN) and exception flags. It has a valid/ready handshake with backpressure on both sides, so the datapath blocks that feed it and consume from it can stall it without losing operations.

Parameters:
N, 32, total operand/result width in bits
E, 8, exponent width; mantissa width M = N-E-1; bias = 2^(E-1)-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_val  input  1  operand beat valid
in_rdy  output  1  block can accept a beat this cycle
sub  input  1  1: compute op1 - op2; 0: compute op1 + op2
op1  input  N  operand 1, {sign, exp[E], mant[M]}
op2  input  N  operand 2, same format
out_val  output  1  result valid
out_rdy  input  1  consumer accepts the result this cycle
res  output  N  result
flags  output  3  {invalid, overflow, inexact}, aligned with res

Behaviour:
- Reset: all stage-valid bits = 0; out_val = 0, res = 0, flags = 0. in_rdy is 1 in the first cycle after reset is released.
- Reset mid-operation discards every in-flight beat. No result is emitted for them.
- Handshake:
  - Input transfer occurs when in_val & in_rdy.
  - Output transfer occurs when out_val & out_rdy.
  - res and flags hold stable while out_val=1 & out_rdy=0.
- Pipeline: 3 registered stages (S1 align, S2 add, S3 normalise/round), each with its own valid bit.
  - Stage k loads when it is empty or its contents move to stage k+1 (or out, for S3) in the same cycle.
  - in_rdy = S1 can load; this is combinational from out_rdy.
  - Latency is 3 cycles from input transfer to out_val with out_rdy held high. Throughput is 1 beat/cycle.
  - With out_rdy=0 the block absorbs exactly 3 beats, then in_rdy=0.
  - Ordering is strictly FIFO. No beat is dropped or duplicated.
- Effective op2 sign = op2.sign ^ sub.
- S1 (align):
  - Classify operands. exp=0 means zero (subnormals are flushed to zero, sign kept). exp=all-ones with mant=0 means Inf. exp=all-ones with mant!=0 means NaN.
  - Swap so |A| >= |B|, comparing exponent then mantissa.
  - Compute d = expA - expB.
  - Shift {1,mantB} right by d into an (M+4)-bit field with guard, round and sticky bits. Sticky is the OR of all bits shifted out. If d >= M+3, B becomes sticky-only.
- S2 (add): if signs match, add; else subtract. The result keeps A's sign and exponent. The width is M+5 bits to hold the carry.
- S3 (normalise/round):
  - On carry-out: shift right 1 (folding the lost bit into sticky) and increment exp.
  - Otherwise: left-shift by the leading-zero count, decrementing exp.
  - RNE: round up iff G & (R | S | lsb). A mantissa overflow from rounding increments exp.
  - inexact = G|R|S before rounding.
  - If the final exp >= all-ones: res = signed Inf, overflow=1, inexact=1.
  - If the final exp <= 0 (underflow): res = signed zero, inexact=1.
- Special cases (these override the datapath; results are otherwise unchanged through the stages):
  - Any NaN input: res = canonical qNaN {0, all-ones exp, 1 followed by zeros}, invalid=1.
  - Inf + (-Inf) effective: canonical qNaN, invalid=1.
  - Inf with a finite operand, or two same-sign Infs: Inf of that sign, no flags.
  - Exact-zero sum of opposite-sign operands: +0.
  - Both operands zero with the same effective sign: zero of that sign.
  - Exactly one zero: the other operand returned unchanged, with sign adjusted for sub when it is op2.

Test Plan:
- op1=0x3F800000, op2=0x3F800000, sub=0, out_rdy=1 -> res=0x40000000, flags=0, out_val exactly 3 cycles after input transfer.
- op1=0x40400000, op2=0x3F800000, sub=1 -> res=0x40000000. Then op1=0x3F800000, op2=0x3F800000, sub=1 -> res=0x00000000 (+0).
- RNE: 0x3F800000+0x33800000 -> 0x3F800000, inexact=1. 0x3F800001+0x33800000 -> 0x3F800002, inexact=1.
- Specials:
  - 0x7F800000+0xFF800000 -> 0x7FC00000, invalid=1.
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
  - 0x7FA00000+0x3F800000 -> 0x7FC00000, invalid=1.
- Backpressure: issue 5 back-to-back beats with out_rdy=0 -> in_rdy falls after 3 accepted. Raise out_rdy -> all 5 results in order, res held stable while stalled.
- Assert rst with 3 beats in flight -> out_val=0 next cycle, no stale results afterward. A fresh beat then completes in 3 cycles.
